seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 179 +++++++++++++++++
 tb/tb_seq_divider.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle non-restoring integer divider with a start/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH:0]   p_reg, p_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             dbz_reg, dbz_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic             done_reg, done_next;
    logic             div_by_zero_reg, div_by_zero_next;

    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   p_iter;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    assign d_ext   = {1'b0, d_reg};
    assign p_shift = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    // The sign of the partial remainder picks subtract (non-negative) or add back.
    assign p_iter  = p_reg[WIDTH] ? (p_shift + d_ext) : (p_shift - d_ext);

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q_reg, neg_q_next;
    logic neg_r_reg, neg_r_next;

    // Magnitudes are unsigned, so the most-negative value maps to 2**(WIDTH-1).
    assign dividend_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign divisor_mag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    assign q_final      = neg_q_reg ? (~q_reg + 1'b1) : q_reg;
    assign r_final      = neg_r_reg ? (~p_reg[WIDTH-1:0] + 1'b1) : p_reg[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else begin
            neg_q_reg <= neg_q_next;
            neg_r_reg <= neg_r_next;
        end
    end

    always_comb begin
        neg_q_next = neg_q_reg;
        neg_r_next = neg_r_reg;
        if (state_reg == IDLE && start && !done_reg) begin
            neg_q_next = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_next = dividend[WIDTH-1];
        end
    end
`else
    assign dividend_mag = dividend;
    assign divisor_mag  = divisor;
    assign q_final      = q_reg;
    assign r_final      = p_reg[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            p_reg           <= '0;
            q_reg           <= '0;
            d_reg           <= '0;
            cnt_reg         <= '0;
            dbz_reg         <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            done_reg        <= 1'b0;
            div_by_zero_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            p_reg           <= p_next;
            q_reg           <= q_next;
            d_reg           <= d_next;
            cnt_reg         <= cnt_next;
            dbz_reg         <= dbz_next;
            quotient_reg    <= quotient_next;
            remainder_reg   <= remainder_next;
            done_reg        <= done_next;
            div_by_zero_reg <= div_by_zero_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        p_next           = p_reg;
        q_next           = q_reg;
        d_next           = d_reg;
        cnt_next         = cnt_reg;
        dbz_next         = dbz_reg;
        quotient_next    = quotient_reg;
        remainder_next   = remainder_reg;
        done_next        = 1'b0;
        div_by_zero_next = div_by_zero_reg;

        case (state_reg)
            IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done_reg) begin
                    p_next   = '0;
                    cnt_next = CNT_W'(WIDTH - 1);
                    d_next   = divisor_mag;
                    if (divisor == '0) begin
                        dbz_next   = 1'b1;
                        q_next     = dividend;
                        state_next = DONE;
                    end else begin
                        dbz_next   = 1'b0;
                        q_next     = dividend_mag;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                p_next = p_iter;
                q_next = {q_reg[WIDTH-2:0], ~p_iter[WIDTH]};
                if (cnt_reg == '0) begin
                    state_next = FIX;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            FIX: begin
                if (p_reg[WIDTH]) begin
                    p_next = p_reg + d_ext;
                end
                state_next = DONE;
            end
            DONE: begin
                done_next        = 1'b1;
                div_by_zero_next = dbz_reg;
                if (dbz_reg) begin
                    quotient_next  = '1;
                    remainder_next = q_reg;
                end else begin
                    quotient_next  = q_final;
                    remainder_next = r_final;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: scoreboard of expected results checked on each done pulse.
module tb_seq_divider;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        int               lat;
    } exp_t;

    exp_t sb[$];

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e.lat = WIDTH + 2;
        e.dbz = 1'b0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) begin
                e.q = a;
                e.r = '0;
            end else begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end
`else
            e.q = a / b;
            e.r = a % b;
`endif
        end
        return e;
    endfunction

    // Launch one operation, optionally holding start high for 'hold' further cycles.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold);
        exp_t e;
        int   cyc;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        chk("busy_after_start", busy, 1);
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            start    = (cyc < hold);
            dividend = 32'h1234_5678 + cyc;
            divisor  = 32'h3;
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
        end
        @(negedge clk);
        start = 1'b0;
        e = sb.pop_front();
        chk("latency", cyc, e.lat);
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dbz);
        $display("op %08h / %08h -> q=%08h r=%08h dbz=%0d lat=%0d", a, b, quotient, remainder,
                 div_by_zero, cyc);
    endtask

    task automatic quiet(input int n, input string tag);
        int dones = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk(tag, dones, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        $display("reset released");

        run_op(32'd3803, 32'd1426, 0);
        run_op(32'd3251, 32'd2489, 0);
        run_op(32'd1426, 32'd3803, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // Divide by zero with start held through busy and done cycles.
        run_op(32'd1426, 32'd0, 2);
        quiet(40, "extra_done_dbz");

        // Start held high during RUN must not restart or queue a second op.
        run_op(32'd1000000, 32'd7, 5);
        quiet(40, "extra_done_run");
        chk("dbz_cleared", div_by_zero, 0);

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op(-32'sd3251, 32'sd2489, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(32'd3251, -32'sd2489, 0);
`endif

        // Reset mid-RUN aborts with no done and clears the result registers.
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd3803;
        divisor  = 32'd1426;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_mid_run", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        @(negedge clk);
        rst = 1'b0;
        quiet(40, "done_after_abort");
        $display("mid-run reset aborted");

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
